// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: parameter defaults, a
// clog2 helper and the elaboration-time builder for the KMP next-state table.
package seq_det_pkg;

    localparam int MAX_PW    = 8;
    localparam int TBL_ST_W  = 3;
    localparam int TBL_W     = MAX_PW * 2 * TBL_ST_W;

    localparam int               DEF_PAT_WIDTH = 4;
    localparam logic [MAX_PW-1:0] DEF_PATTERN  = 8'b0000_1101;
    localparam bit               DEF_OVERLAP   = 1'b1;
    localparam int               DEF_CNT_WIDTH = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Entry (2*k + b) holds the next state from state k on input bit b. The
    // longest prefix that is also a suffix of (matched prefix + b), capped
    // below the full length, covers advance, KMP fallback and overlap restart.
    function automatic logic [TBL_W-1:0] build_next_table(
        input int               pw,
        input logic [MAX_PW-1:0] pat,
        input bit               ovl
    );
        logic [TBL_W-1:0]  tbl;
        logic [MAX_PW-1:0] sh;
        int                best;
        int                pos;
        bit                eq;
        bit                pb;
        bit                sb;
        bit                last;
        tbl  = {TBL_W{1'b0}};
        sh   = pat;
        last = sh[0];
        for (int k = 0; k < MAX_PW; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                if (k < pw) begin
                    for (int l = 1; l < MAX_PW; l++) begin
                        if ((l <= k + 1) && (l < pw)) begin
                            eq = 1'b1;
                            for (int i = 0; i < MAX_PW; i++) begin
                                if (i < l) begin
                                    sh  = pat >> (pw - 1 - i);
                                    pb  = sh[0];
                                    pos = k + 1 - l + i;
                                    if (pos == k) begin
                                        sb = (b == 1);
                                    end else begin
                                        sh = pat >> (pw - 1 - pos);
                                        sb = sh[0];
                                    end
                                    if (pb != sb) begin
                                        eq = 1'b0;
                                    end
                                end
                            end
                            if (eq) begin
                                best = l;
                            end
                        end
                    end
                    if (!ovl && (k == pw - 1) && ((b == 1) == last)) begin
                        best = 0;
                    end
                end
                tbl = tbl | (TBL_W'(best) << ((2 * k + b) * TBL_ST_W));
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating match counter with a sticky saturation flag; clear beats increment.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_inc_s;
    logic                 sat_r;

    // Incremented value used by the register update.
    always_comb begin
        count_inc_s = count_r + CNT_WIDTH'(1'b1);
    end

    // Counter and sticky flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_WIDTH{1'b0}};
            sat_r   <= 1'b0;
        end else if (clr) begin
            count_r <= {CNT_WIDTH{1'b0}};
            sat_r   <= 1'b0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_inc_s;
            sat_r   <= (count_inc_s == CNT_MAX);
        end else begin
            count_r <= count_r;
            sat_r   <= sat_r;
        end
    end

    assign count = count_r;
    assign sat   = sat_r;

endmodule

// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector: state = number of pattern prefix bits matched,
// transitions taken from a KMP table built at elaboration, plus match counter.
module mealy_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                   PAT_WIDTH = DEF_PAT_WIDTH,
    parameter logic [PAT_WIDTH-1:0] PATTERN   = DEF_PATTERN[PAT_WIDTH-1:0],
    parameter bit                   OVERLAP   = DEF_OVERLAP,
    parameter int                   CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          inp,
    input  logic                          inp_valid,
    input  logic                          clear_count,
    output logic                          outp,
    output logic [CNT_WIDTH-1:0]          match_count,
    output logic                          sat,
    output logic [clog2(PAT_WIDTH)-1:0]   state_dbg
);

    localparam int               ST_W     = clog2(PAT_WIDTH);
    localparam logic [TBL_W-1:0] NEXT_TBL = build_next_table(PAT_WIDTH, MAX_PW'(PATTERN), OVERLAP);
    localparam logic             LAST_BIT = PATTERN[0];

    typedef logic [ST_W-1:0] state_t;

    localparam state_t S_LAST = state_t'(PAT_WIDTH - 1);

    state_t state_r;
    state_t state_next_s;
    logic   match_s;

    // Next state from the table when a bit is consumed, Mealy match flag.
    always_comb begin
        state_next_s = state_r;
        match_s      = 1'b0;
        if (inp_valid) begin
            state_next_s = ST_W'(NEXT_TBL >> (TBL_ST_W * (2 * int'(state_r) + int'(inp))));
        end else begin
            state_next_s = state_r;
        end
        if (!reset && inp_valid && (state_r == S_LAST) && (inp == LAST_BIT)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= {ST_W{1'b0}};
        end else begin
            state_r <= state_next_s;
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sat_counter (
        .clock (clock),
        .reset (reset),
        .inc   (match_s),
        .clr   (clear_count),
        .count (match_count),
        .sat   (sat)
    );

    assign outp      = match_s;
    assign state_dbg = state_r;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench for mealy_seq_detector across four parameterisations.
module tb_mealy_seq_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [4];
    logic inp [4];
    logic vld [4];
    logic clr [4];

    logic       o0, o1, o2, o3;
    logic       s0, s1, s2, s3;
    logic [7:0] mc0, mc1, mc3;
    logic [1:0] mc2;
    logic [1:0] sd0, sd1, sd2, sd3;

    int nchecks = 0;
    int nerrors = 0;
    bit expq [$];

    mealy_seq_detector u0 (
        .clock(clk), .reset(rst[0]), .inp(inp[0]), .inp_valid(vld[0]), .clear_count(clr[0]),
        .outp(o0), .match_count(mc0), .sat(s0), .state_dbg(sd0));

    mealy_seq_detector #(.OVERLAP(1'b0)) u1 (
        .clock(clk), .reset(rst[1]), .inp(inp[1]), .inp_valid(vld[1]), .clear_count(clr[1]),
        .outp(o1), .match_count(mc1), .sat(s1), .state_dbg(sd1));

    mealy_seq_detector #(.CNT_WIDTH(2)) u2 (
        .clock(clk), .reset(rst[2]), .inp(inp[2]), .inp_valid(vld[2]), .clear_count(clr[2]),
        .outp(o2), .match_count(mc2), .sat(s2), .state_dbg(sd2));

    mealy_seq_detector #(.PAT_WIDTH(3), .PATTERN(3'b111), .OVERLAP(1'b1)) u3 (
        .clock(clk), .reset(rst[3]), .inp(inp[3]), .inp_valid(vld[3]), .clear_count(clr[3]),
        .outp(o3), .match_count(mc3), .sat(s3), .state_dbg(sd3));

    function automatic logic outp_of(input int d);
        case (d)
            0:       return o0;
            1:       return o1;
            2:       return o2;
            3:       return o3;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a consumed bit pops one expectation; otherwise outp must be low.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rst[d] === 1'b1 || vld[d] !== 1'b1) begin
                chk($sformatf("outp_idle_u%0d", d), 32'(outp_of(d)), 32'd0);
            end else if (expq.size() == 0) begin
                nchecks++;
                nerrors++;
                $display("FAIL scoreboard_underflow_u%0d: got outp=%0d with no expectation", d, outp_of(d));
            end else begin
                chk($sformatf("outp_u%0d", d), 32'(outp_of(d)), 32'(expq.pop_front()));
            end
        end
    end

    task automatic send(input int d, input logic b, input logic v, input logic e,
                        input logic c = 1'b0, input logic r = 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            clr[i] = 1'b0;
            rst[i] = 1'b0;
        end
        inp[d] = b;
        vld[d] = v;
        clr[d] = c;
        rst[d] = r;
        if (v && !r) expq.push_back(e);
    endtask

    task automatic send_seq(input int d, input int n, input logic [15:0] bits, input logic [15:0] exps);
        logic [15:0] tb;
        logic [15:0] te;
        for (int i = 0; i < n; i++) begin
            tb = bits >> (n - 1 - i);
            te = exps >> (n - 1 - i);
            send(d, tb[0], 1'b1, te[0]);
        end
    endtask

    task automatic idle_then_sample();
        send(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            inp[i] = 1'b0;
            vld[i] = 1'b0;
            clr[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        @(negedge clk);
        chk("rst_mc0", 32'(mc0), 32'd0); chk("rst_sat0", 32'(s0), 32'd0); chk("rst_sd0", 32'(sd0), 32'd0);
        chk("rst_mc1", 32'(mc1), 32'd0); chk("rst_sat1", 32'(s1), 32'd0); chk("rst_sd1", 32'(sd1), 32'd0);
        chk("rst_mc2", 32'(mc2), 32'd0); chk("rst_sat2", 32'(s2), 32'd0); chk("rst_sd2", 32'(sd2), 32'd0);
        chk("rst_mc3", 32'(mc3), 32'd0); chk("rst_sat3", 32'(s3), 32'd0); chk("rst_sd3", 32'(sd3), 32'd0);

        // Overlapping 1101 on 1101101: matches on bits 4 and 7.
        send_seq(0, 7, 16'b1101101, 16'b0001001);
        idle_then_sample();
        chk("ovl_count", 32'(mc0), 32'd2);
        chk("ovl_state", 32'(sd0), 32'd1);

        // Non-overlapping: only bit 4 matches and the FSM restarts at S0.
        send_seq(1, 4, 16'b1101, 16'b0001);
        idle_then_sample();
        chk("novl_state_after_match", 32'(sd1), 32'd0);
        chk("novl_count_mid", 32'(mc1), 32'd1);
        send_seq(1, 3, 16'b101, 16'b000);
        idle_then_sample();
        chk("novl_count", 32'(mc1), 32'd1);
        chk("novl_state_end", 32'(sd1), 32'd1);

        // Gap with inp_valid low and inp toggling holds S3.
        send(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_seq(0, 3, 16'b110, 16'b000);
        for (int g = 0; g < 3; g++) begin
            send(0, (g % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("gap_state_%0d", g), 32'(sd0), 32'd3);
        end
        send(0, 1'b1, 1'b1, 1'b1);
        idle_then_sample();
        chk("gap_count", 32'(mc0), 32'd1);

        // Reset from S3 with a would-be final bit: no match, progress discarded.
        send(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_seq(0, 3, 16'b110, 16'b000);
        send(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(0, 1'b1, 1'b1, 1'b0);
        idle_then_sample();
        chk("rst_mid_state", 32'(sd0), 32'd1);
        chk("rst_mid_count", 32'(mc0), 32'd0);

        // KMP fallback: from S1, 1,1 stays in S2, then 0,1 completes a match.
        send_seq(0, 4, 16'b1101, 16'b0001);
        idle_then_sample();
        chk("kmp_count", 32'(mc0), 32'd1);
        chk("kmp_state", 32'(sd0), 32'd1);

        // 2-bit counter saturates at 3 after four matches.
        send_seq(2, 13, 16'b1101101101101, 16'b0001001001001);
        idle_then_sample();
        chk("sat_count", 32'(mc2), 32'd3);
        chk("sat_flag", 32'(s2), 32'd1);
        chk("sat_state", 32'(sd2), 32'd1);
        // Clear coinciding with a fifth match: outp still fires, counter clears.
        send_seq(2, 2, 16'b10, 16'b00);
        send(2, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_then_sample();
        chk("clr_count", 32'(mc2), 32'd0);
        chk("clr_sat", 32'(s2), 32'd0);
        chk("clr_state", 32'(sd2), 32'd1);

        // Pattern 111 with overlap: matches on bits 3, 4 and 5.
        send_seq(3, 5, 16'b11111, 16'b00111);
        idle_then_sample();
        chk("p111_count", 32'(mc3), 32'd3);
        chk("p111_state", 32'(sd3), 32'd2);

        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/mealy_seq_detector.md
MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

Interface
REQ-001 Parameter PAT_WIDTH, default 4; pattern length in bits, legal range 2..8.
REQ-002 Parameter PATTERN, default 4'b1101, width PAT_WIDTH; the pattern to detect; bit PAT_WIDTH-1 is received first.
REQ-003 Parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 Parameter CNT_WIDTH, default 8; width of the match counter.
REQ-005 clock  input  1  single clock; all state updates occur on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 inp  input  1  serial data bit.
REQ-008 inp_valid  input  1  qualifies inp; a bit is consumed only when inp_valid=1.
REQ-009 clear_count  input  1  synchronous clear of match_count and sat.
REQ-010 outp  output  1  Mealy match flag; combinational from the current state, inp and inp_valid.
REQ-011 match_count  output  CNT_WIDTH  number of matches since reset or clear; saturating.
REQ-012 sat  output  1  sticky flag; set when match_count reaches all-ones.
REQ-013 state_dbg  output  clog2(PAT_WIDTH)  current state, equal to the number of pattern prefix bits matched.

Function
REQ-014 States S0..S(PAT_WIDTH-1); state k means the last k consumed bits equal the first k bits of PATTERN.
REQ-015 outp SHALL be 1 in the same cycle as the final pattern bit when: state = PAT_WIDTH-1, inp_valid=1, and inp equals the last pattern bit; otherwise outp=0; zero added latency.
REQ-016 Non-final transition: if inp_valid=1 and inp matches the next pattern bit, advance to S(k+1).
REQ-017 Mismatch: go to the longest proper prefix of PATTERN that is also a suffix of the consumed history plus inp (KMP failure function); this includes S0 or S1 as applicable.
REQ-018 Failure and next-state tables SHALL be computed at elaboration from PATTERN; no runtime pattern storage.
REQ-019 On match with OVERLAP=1, next state = longest proper prefix that is a suffix of the full pattern.
REQ-020 On match with OVERLAP=0, next state = S0.
REQ-021 inp_valid=0: state, match_count and sat hold; outp=0.
REQ-022 On each outp=1 cycle, match_count increments by 1 unless it is all-ones; when it becomes all-ones, sat is set.
REQ-023 clear_count=1 sets match_count=0 and sat=0 at the next edge; clear_count wins over a simultaneous match.
REQ-024 clear_count SHALL NOT affect the FSM state or outp.

Reset
REQ-025 On a clock edge with reset=1: state=S0, match_count=0, sat=0; this takes priority over all other inputs.
REQ-026 While reset=1, outp=0 regardless of inp and inp_valid.
REQ-027 Reset mid-pattern discards all partial progress; the first bit after reset is evaluated from S0.

Structure
REQ-028 Shared package seq_det_pkg SHALL hold the clog2 helper function, the parameter defaults, and the elaboration function that builds the KMP next-state table.
REQ-029 One sub-module, sat_counter (parameter CNT_WIDTH; inputs inc and clr; outputs count and sat), SHALL implement REQ-022 and REQ-023.
REQ-030 The FSM SHALL be one registered state variable plus combinational next-state and output logic; no input shift register.

Verification
REQ-031 Defaults, reset 1 cycle, valid stream 1,1,0,1,1,0,1 -> outp=1 on bits 4 and 7 only; match_count=2.
REQ-032 OVERLAP=0, same stream -> outp=1 on bit 4 only; match_count=1; state_dbg=0 after bit 4.
REQ-033 Stream 1,1,0 with valid, then 3 cycles with inp_valid=0 and inp toggling, then valid 1 -> outp=1 on the final valid bit; state_dbg holds 3 during the gap.
REQ-034 Stream 1,1,0, then reset for 1 cycle, then valid 1 -> outp=0; state_dbg=1.
REQ-035 CNT_WIDTH=2, 4 matches -> match_count stays 3 with sat=1; then clear_count asserted in the cycle of a 5th match -> match_count=0, sat=0.
REQ-036 PAT_WIDTH=3, PATTERN=3'b111, OVERLAP=1, five valid 1s -> outp=1 on bits 3, 4 and 5; match_count=3.
